etapa_ex_muldiv: RTL and testbench
==================================

Name: etapa_ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the latched register operands and a decoded op code from ID/EX.
- Performs MULT/MULTU/DIV/DIVU over NBITS cycles and holds the architectural HI/LO registers.
- Drives a busy stall request to the hazard logic so dependent instructions and MFHI/MFLO wait.

Parameters:
- NBITS, 32, operand/HI/LO width.
- CNTBITS, 6, iteration-counter width; must satisfy 2^CNTBITS > NBITS.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  start request; sampled only when the unit is not busy.
- i_op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- i_Registro1  in  NBITS  rs operand (multiplicand / dividend).
- i_Registro2  in  NBITS  rt operand (multiplier / divisor).
- i_MTHI  in  1  write i_Registro1 into HI.
- i_MTLO  in  1  write i_Registro1 into LO.
- o_busy  out  1  operation in progress; stall request.
- o_done  out  1  one-cycle pulse; HI/LO hold the new result.
- o_HI  out  NBITS  HI register.
- o_LO  out  NBITS  LO register.

Behaviour:
- Reset: state IDLE, o_busy=0, o_done=0, o_HI=0, o_LO=0, counter=0, internal operands cleared.
- Reset wins over every other input, including mid-operation: the result is discarded and no o_done pulse is produced.
- States:
  - IDLE: waiting for work.
  - MUL: running a multiply.
  - DIV: running a divide.
  - DONE: results valid, o_done=1.
- Transitions:
  - IDLE or DONE with i_start=1 at edge E0 -> MUL (i_op[1]=0) or DIV (i_op[1]=1). Operands are captured as magnitudes for signed ops, together with the result-sign flags.
  - MUL/DIV -> DONE at edge E0+NBITS.
  - DONE -> IDLE on the next edge when i_start=0.
- Latency:
  - o_busy=1 for exactly NBITS cycles (cycles after E0 through E0+NBITS-1).
  - After E0+NBITS: o_busy=0, o_done=1, HI/LO updated.
- Multiply:
  - Shift-add, 1 bit per cycle, 2*NBITS product.
  - HI = upper half, LO = lower half.
  - MULT: the product is negated at completion if the operand signs differ.
- Divide:
  - Restoring, 1 quotient bit per cycle.
  - LO = quotient, HI = remainder.
  - DIV: the quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - Divide by zero (both ops): LO = all ones, HI = dividend. Runs the full NBITS cycles.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- While busy:
  - i_start is ignored (no queueing).
  - i_MTHI/i_MTLO are ignored.
  - Operand inputs may change freely.
- MTHI/MTLO in IDLE or DONE: the register is written at the edge. If i_start and MTHI/MTLO are asserted in the same cycle, start is taken and the MT write is dropped.
- i_start in DONE begins the new op; o_done still pulses for the completed one in that cycle.
- All arithmetic is modulo width. Internal accumulators are 2*NBITS+1 bits wide.

Optional Feature:
- Macro: MULDIV_DIV_EN.
- Defined: full behaviour as above.
- Undefined:
  - Divider datapath and DIV state are not built.
  - i_op DIV/DIVU with i_start: no busy; o_done pulses for 1 cycle after E0; HI/LO unchanged.
  - MULT/MULTU are unaffected.

Test Plan:
- MULTU 0xFFFFFFFF x 0x00000002 -> o_busy high for 32 cycles, then o_done=1, HI=0x00000001, LO=0xFFFFFFFE.
- MULT 0xFFFFFFFD (-3) x 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> LO=0xFFFFFFFF, HI=0x00000007.
- Start MULTU 5x5, pulse i_start with other operands and i_MTHI mid-run -> result HI=0, LO=25 only; one o_done; busy 32 cycles.
- Start DIVU 100/3, assert i_reset at cycle 10 -> next cycle o_busy=0, HI=LO=0, no o_done; a following MTLO 0x1234 -> LO=0x1234.
- Build with MULDIV_DIV_EN undefined, DIV 9/3 with HI=LO=0xAA preset -> o_busy never high, o_done at cycle 1, HI=LO=0xAA.

Source files
------------

// File: rtl/etapa_ex_muldiv.sv
// etapa_ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit for the EX stage, owns the HI/LO registers.
// Optional divider is built only when MULDIV_DIV_EN is defined; otherwise DIV/DIVU complete at once with HI/LO unchanged.
module etapa_ex_muldiv #(
    parameter int NBITS   = 32,
    parameter int CNTBITS = 6
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [NBITS-1:0] i_Registro1,
    input  logic [NBITS-1:0] i_Registro2,
    input  logic             i_MTHI,
    input  logic             i_MTLO,
    output logic             o_busy,
    output logic             o_done,
    output logic [NBITS-1:0] o_HI,
    output logic [NBITS-1:0] o_LO
);

    // state | meaning
    // IDLE  | waiting for work
    // MUL   | shift-add multiply, one bit per cycle
    // DIV   | restoring divide, one quotient bit per cycle
    // DONE  | HI/LO hold the new result, o_done high
`ifdef MULDIV_DIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd3} state_t;
`endif

    localparam int AW = 2*NBITS + 1;

    state_t               state, state_nxt;
    logic [CNTBITS-1:0]   cnt;
    logic [AW-1:0]        acc;
    logic [NBITS-1:0]     opb;
    logic                 neg_res;
    logic [NBITS-1:0]     hi, lo;

    logic                 idle_like, take_start, last_step, signed_op;
    logic [NBITS-1:0]     mag_a, mag_b;
    logic [NBITS:0]       mul_sum;
    logic [AW-1:0]        mul_acc;
    logic [2*NBITS-1:0]   prod;

    assign idle_like  = (state == IDLE) || (state == DONE);
    assign take_start = idle_like && i_start;
    assign last_step  = (cnt == '0);
    assign signed_op  = ~i_op[0];

    assign mag_a = (signed_op && i_Registro1[NBITS-1]) ? -i_Registro1 : i_Registro1;
    assign mag_b = (signed_op && i_Registro2[NBITS-1]) ? -i_Registro2 : i_Registro2;

    // Multiplier sits in the low half of acc and is consumed LSB first.
    assign mul_sum = acc[AW-1:NBITS] + (acc[0] ? {1'b0, opb} : '0);
    assign mul_acc = {1'b0, mul_sum, acc[NBITS-1:1]};
    assign prod    = neg_res ? -mul_acc[2*NBITS-1:0] : mul_acc[2*NBITS-1:0];

`ifdef MULDIV_DIV_EN
    logic                 neg_rem, div_zero;
    logic [AW-1:0]        div_shift, div_acc;
    logic [NBITS:0]       div_diff;
    logic                 div_ge;
    logic [NBITS-1:0]     quo, rem, hi_res, lo_res;

    // Partial remainder in the upper NBITS+1 bits, dividend shifts out of / quotient shifts into the low half.
    assign div_shift = {acc[AW-2:0], 1'b0};
    assign div_ge    = div_shift[AW-1:NBITS] >= {1'b0, opb};
    assign div_diff  = div_shift[AW-1:NBITS] - {1'b0, opb};
    assign div_acc   = div_ge ? {div_diff, div_shift[NBITS-1:1], 1'b1} : div_shift;
    assign quo       = div_acc[NBITS-1:0];
    assign rem       = div_acc[2*NBITS-1:NBITS];
    // A zero divisor leaves |dividend| as remainder, so re-signing it restores the raw dividend.
    assign lo_res    = div_zero ? '1 : (neg_res ? -quo : quo);
    assign hi_res    = neg_rem ? -rem : rem;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (i_start) begin
                    if (!i_op[1])
                        state_nxt = MUL;
                    else
`ifdef MULDIV_DIV_EN
                        state_nxt = DIV;
`else
                        state_nxt = DONE;
`endif
                end else if (state == DONE) begin
                    state_nxt = IDLE;
                end
            end
            MUL: if (last_step) state_nxt = DONE;
`ifdef MULDIV_DIV_EN
            DIV: if (last_step) state_nxt = DONE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            opb     <= '0;
            neg_res <= 1'b0;
            hi      <= '0;
            lo      <= '0;
`ifdef MULDIV_DIV_EN
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (take_start) begin
                cnt     <= CNTBITS'(NBITS - 1);
                acc     <= {{(NBITS+1){1'b0}}, mag_a};
                opb     <= mag_b;
                neg_res <= signed_op && (i_Registro1[NBITS-1] ^ i_Registro2[NBITS-1]);
`ifdef MULDIV_DIV_EN
                neg_rem  <= signed_op && i_Registro1[NBITS-1];
                div_zero <= (i_Registro2 == '0);
`endif
            end else if (idle_like) begin
                if (i_MTHI) hi <= i_Registro1;
                if (i_MTLO) lo <= i_Registro1;
            end else begin
                cnt <= cnt - CNTBITS'(1);
                case (state)
                    MUL: begin
                        acc <= mul_acc;
                        if (last_step) begin
                            hi <= prod[2*NBITS-1:NBITS];
                            lo <= prod[NBITS-1:0];
                        end
                    end
`ifdef MULDIV_DIV_EN
                    DIV: begin
                        acc <= div_acc;
                        if (last_step) begin
                            hi <= hi_res;
                            lo <= lo_res;
                        end
                    end
`endif
                    default: acc <= acc;
                endcase
            end
        end
    end

    assign o_busy = (state == MUL)
`ifdef MULDIV_DIV_EN
                    || (state == DIV)
`endif
                    ;
    assign o_done = (state == DONE);
    assign o_HI   = hi;
    assign o_LO   = lo;

endmodule

// File: tb/tb_etapa_ex_muldiv.sv
// Self-checking bench for etapa_ex_muldiv; expectations adapt to whether MULDIV_DIV_EN is defined.
module tb_etapa_ex_muldiv;
    localparam int NBITS = 32;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset, i_start, i_MTHI, i_MTLO;
    logic [1:0]  i_op;
    logic [31:0] i_Registro1, i_Registro2;
    logic        o_busy, o_done;
    logic [31:0] o_HI, o_LO;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] sb_q[$];
    logic [31:0] sh_hi, sh_lo;

    always #5 i_clk = ~i_clk;

    etapa_ex_muldiv #(.NBITS(NBITS), .CNTBITS(6)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
        .i_Registro1(i_Registro1), .i_Registro2(i_Registro2),
        .i_MTHI(i_MTHI), .i_MTLO(i_MTLO),
        .o_busy(o_busy), .o_done(o_done), .o_HI(o_HI), .o_LO(o_LO)
    );

    initial begin
        #500000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "timeout");
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [63:0] model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00:   r = sa * sb;
            2'b01:   r = ua * ub;
            2'b10:   r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            default: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
        endcase
        return r;
    endfunction

    // Without the divider a DIV/DIVU leaves HI/LO as they were.
    function automatic logic [63:0] exp_div(logic [63:0] v);
        return DIV_EN ? v : {sh_hi, sh_lo};
    endfunction

    task automatic mt_write(bit hi_en, bit lo_en, logic [31:0] val);
        i_MTHI = hi_en;
        i_MTLO = lo_en;
        i_Registro1 = val;
        next_cycle();
        i_MTHI = 1'b0;
        i_MTLO = 1'b0;
        if (hi_en) sh_hi = val;
        if (lo_en) sh_lo = val;
        chk("mt hi", {32'd0, o_HI}, {32'd0, sh_hi});
        chk("mt lo", {32'd0, o_LO}, {32'd0, sh_lo});
    endtask

    task automatic run_op(string tag, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                          logic [63:0] exp, bit disturb, bit mt_at_start);
        int          cyc = 0;
        int          busy_cnt = 0;
        int          lat;
        logic [63:0] got;
        lat = (op[1] && !DIV_EN) ? 0 : NBITS;
        sb_q.push_back(exp);
        i_start = 1'b1;
        i_op = op;
        i_Registro1 = a;
        i_Registro2 = b;
        i_MTHI = mt_at_start;
        i_MTLO = mt_at_start;
        next_cycle();
        i_start = 1'b0;
        i_MTHI = 1'b0;
        i_MTLO = 1'b0;
        if (mt_at_start && lat != 0)
            chk({tag, " mt dropped"}, {o_HI, o_LO}, {sh_hi, sh_lo});
        while (!o_done && cyc < 4*NBITS) begin
            if (o_busy) busy_cnt++;
            cyc++;
            i_Registro1 = $urandom;
            i_Registro2 = $urandom;
            i_op = 2'($urandom_range(0, 3));
            i_start = disturb && (cyc == 5);
            i_MTHI = disturb && (cyc == 5);
            i_MTLO = disturb && (cyc == 5);
            next_cycle();
        end
        i_start = 1'b0;
        i_MTHI = 1'b0;
        i_MTLO = 1'b0;
        chk({tag, " done"}, 64'(o_done), 64'd1);
        chk({tag, " latency"}, 64'(cyc), 64'(lat));
        chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(lat));
        got = {o_HI, o_LO};
        if (sb_q.size() > 0)
            chk({tag, " result"}, got, sb_q.pop_front());
        next_cycle();
        chk({tag, " single pulse"}, {62'd0, o_busy, o_done}, 64'd0);
        sh_hi = exp[63:32];
        sh_lo = exp[31:0];
    endtask

    initial begin
        int          done_cnt;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] rexp;

        i_reset = 1'b1;
        i_start = 1'b0;
        i_MTHI = 1'b0;
        i_MTLO = 1'b0;
        i_op = 2'b00;
        i_Registro1 = '0;
        i_Registro2 = '0;
        sh_hi = '0;
        sh_lo = '0;
        repeat (3) next_cycle();
        i_reset = 1'b0;
        chk("reset busy", 64'(o_busy), 64'd0);
        chk("reset done", 64'(o_done), 64'd0);
        chk("reset hi", {32'd0, o_HI}, 64'd0);
        chk("reset lo", {32'd0, o_LO}, 64'd0);

        run_op("multu ffffffff*2", 2'b01, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE, 0, 0);
        run_op("mult -3*7", 2'b00, 32'hFFFF_FFFD, 32'h7, 64'hFFFF_FFFF_FFFF_FFEB, 0, 1);
        run_op("mult -5*-6", 2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 64'h0000_0000_0000_001E, 0, 0);
        run_op("mult min*min", 2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 0);
        run_op("multu max*max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 0);

        mt_write(1, 1, 32'h0000_00AA);
        run_op("div 9/3", 2'b10, 32'd9, 32'd3, exp_div(64'h0000_0000_0000_0003), 0, 1);
        run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'h2, exp_div(64'hFFFF_FFFF_FFFF_FFFD), 0, 0);
        run_op("divu 7/0", 2'b11, 32'h7, 32'h0, exp_div(64'h0000_0007_FFFF_FFFF), 0, 0);
        run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, exp_div(64'h0000_0000_8000_0000), 0, 0);
        run_op("div -7/0", 2'b10, 32'hFFFF_FFF9, 32'h0, exp_div(64'hFFFF_FFF9_FFFF_FFFF), 0, 0);
        run_op("div 7/-2", 2'b10, 32'h7, 32'hFFFF_FFFE, exp_div(64'h0000_0001_FFFF_FFFD), 0, 0);

        run_op("multu 5*5 disturbed", 2'b01, 32'd5, 32'd5, 64'h0000_0000_0000_0019, 1, 0);

        for (int k = 0; k < 8; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            rexp = (rop[1] && !DIV_EN) ? {sh_hi, sh_lo} : model(rop, ra, rb);
            run_op($sformatf("rand%0d op%0d %h/%h", k, rop, ra, rb), rop, ra, rb, rexp, 0, 0);
        end

        mt_write(1, 1, 32'h5555_AAAA);
        i_start = 1'b1;
        i_op = DIV_EN ? 2'b11 : 2'b01;
        i_Registro1 = 32'd100;
        i_Registro2 = 32'd3;
        next_cycle();
        i_start = 1'b0;
        repeat (9) next_cycle();
        chk("pre-reset busy", 64'(o_busy), 64'd1);
        i_reset = 1'b1;
        next_cycle();
        i_reset = 1'b0;
        chk("abort busy", 64'(o_busy), 64'd0);
        chk("abort done", 64'(o_done), 64'd0);
        chk("abort hi", {32'd0, o_HI}, 64'd0);
        chk("abort lo", {32'd0, o_LO}, 64'd0);
        sh_hi = '0;
        sh_lo = '0;
        done_cnt = 0;
        repeat (40) begin
            if (o_done) done_cnt++;
            next_cycle();
        end
        chk("abort no done", 64'(done_cnt), 64'd0);
        mt_write(0, 1, 32'h0000_1234);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
